// File: rtl/fifo_simple.sv
// Single-clock show-ahead FIFO: the head entry is always visible on read_data.
// Writes to a full FIFO and reads from an empty FIFO are dropped. A read and a
// write on a full FIFO are both accepted, so the freed slot is refilled.
// Optional build macro FIFO_SIMPLE_ERR_FLAGS_EN adds registered overflow and
// underflow pulse outputs that flag rejected writes and reads.
module fifo_simple #(
   parameter int FIFO_DEPTH      = 4,
   parameter int FIFO_DATA_WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       write,
   input  logic                       read,
   input  logic [FIFO_DATA_WIDTH-1:0] write_data,
   output logic [FIFO_DATA_WIDTH-1:0] read_data,
   output logic                       empty,
`ifdef FIFO_SIMPLE_ERR_FLAGS_EN
   output logic                       full,
   output logic                       overflow,
   output logic                       underflow
`else
   output logic                       full
`endif
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

   logic [FIFO_DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]           wptr;
   logic [PTR_W-1:0]           rptr;
   logic [CNT_W-1:0]           count;
   logic                       rd_acc;
   logic                       wr_acc;

   // Pointers wrap explicitly so that depths which are not a power of two work.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   // A write on a full FIFO is still accepted when the same edge pops the head.
   assign rd_acc = read && !empty;
   assign wr_acc = write && (!full || rd_acc);

   // Both flags come from the registered count and change only after an edge.
   assign empty = (count == '0);
   assign full  = (count == FULL_CNT);

   // Storage array, written only when a write is accepted.
   // NOTE: the data array has no reset. Pointers and count define which entries
   // are valid, and leaving the array out of reset lets it map to plain RAM.
   always_ff @(posedge clk) begin
      if (!reset && wr_acc) begin
         mem[wptr] <= write_data;
      end
   end

   // Pointer and occupancy registers, with reset taking priority over traffic.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the values from before the edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (wr_acc) wptr <= next_ptr(wptr);
         if (rd_acc) rptr <= next_ptr(rptr);
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Show-ahead output: the head entry, forced to zero while the FIFO is empty.
   // NOTE: the default assignment comes first, so every path assigns read_data
   // and no latch is inferred.
   always_comb begin
      read_data = '0;
      if (!empty) begin
         read_data = mem[rptr];
      end
   end

`ifdef FIFO_SIMPLE_ERR_FLAGS_EN
   // One-cycle pulses that flag a write or read rejected at the previous edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= write && !wr_acc;
         underflow <= read && empty;
      end
   end
`endif

endmodule

// File: tb/tb_fifo_simple.sv
// Scoreboard bench for fifo_simple (depth 4, width 8).
// A stimulus process drives one directed vector each clock and queues the
// hand-computed state expected after that edge. A separate monitor pops one
// expectation #1 after every rising edge and compares it with the outputs.
module tb_fifo_simple;

   typedef struct {
      string      name;
      logic [7:0] rd;
      logic       e;
      logic       f;
      logic       ovf;
      logic       unf;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       write;
   logic       read;
   logic [7:0] write_data;
   logic [7:0] read_data;
   logic       empty;
   logic       full;
`ifdef FIFO_SIMPLE_ERR_FLAGS_EN
   logic       overflow;
   logic       underflow;
`endif

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   fifo_simple #(.FIFO_DEPTH(4), .FIFO_DATA_WIDTH(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .write      (write),
      .read       (read),
      .write_data (write_data),
      .read_data  (read_data),
      .empty      (empty),
`ifdef FIFO_SIMPLE_ERR_FLAGS_EN
      .full       (full),
      .overflow   (overflow),
      .underflow  (underflow)
`else
      .full       (full)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Drive one vector at the falling edge and queue the expected post-edge state.
   task automatic step(input string name, input logic rst, input logic w, input logic r,
                       input logic [7:0] wd, input logic [7:0] rd, input logic e,
                       input logic f, input logic ovf, input logic unf);
      exp_t x;
      @(negedge clk);
      reset      = rst;
      write      = w;
      read       = r;
      write_data = wd;
      x.name = name; x.rd = rd; x.e = e; x.f = f; x.ovf = ovf; x.unf = unf;
      exp_q.push_back(x);
   endtask

   // Monitor: compares each expectation just after the edge it describes.
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            check({x.name, ".read_data"}, 32'(read_data), 32'(x.rd));
            check({x.name, ".empty"},     32'(empty),     32'(x.e));
            check({x.name, ".full"},      32'(full),      32'(x.f));
`ifdef FIFO_SIMPLE_ERR_FLAGS_EN
            check({x.name, ".overflow"},  32'(overflow),  32'(x.ovf));
            check({x.name, ".underflow"}, 32'(underflow), 32'(x.unf));
`endif
         end
      end
   end

   // Stimulus: directed vectors with hand-computed expected values.
   initial begin
      int budget;
      reset = 1'b1; write = 1'b0; read = 1'b0; write_data = '0;

      //    name        rst w  r  wdata  rd     e  f  ovf unf
      step("reset0",    1, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0);
      step("reset1",    1, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0);

      // Overfill with 0..7; writes 4..7 are dropped.
      for (int i = 0; i < 8; i++)
         step($sformatf("fill%0d", i), 0, 1, 0, 8'(i), 8'h00, 0, (i >= 3), (i >= 4), 0);

      // Overdrain: the head advances 1,2,3, then the FIFO runs empty.
      step("drain0",    0, 0, 1, 8'h00, 8'h01, 0, 0, 0, 0);
      step("drain1",    0, 0, 1, 8'h00, 8'h02, 0, 0, 0, 0);
      step("drain2",    0, 0, 1, 8'h00, 8'h03, 0, 0, 0, 0);
      step("drain3",    0, 0, 1, 8'h00, 8'h00, 1, 0, 0, 0);
      step("drain4",    0, 0, 1, 8'h00, 8'h00, 1, 0, 0, 1);
      step("drain5",    0, 0, 1, 8'h00, 8'h00, 1, 0, 0, 1);

      // Wrap-around: write 16..23 (20..23 are dropped), then six reads.
      for (int i = 0; i < 8; i++)
         step($sformatf("wrapw%0d", i), 0, 1, 0, 8'(16 + i), 8'd16, 0, (i >= 3), (i >= 4), 0);
      step("wrapr0",    0, 0, 1, 8'h00, 8'd17, 0, 0, 0, 0);
      step("wrapr1",    0, 0, 1, 8'h00, 8'd18, 0, 0, 0, 0);
      step("wrapr2",    0, 0, 1, 8'h00, 8'd19, 0, 0, 0, 0);
      step("wrapr3",    0, 0, 1, 8'h00, 8'h00, 1, 0, 0, 0);
      step("wrapr4",    0, 0, 1, 8'h00, 8'h00, 1, 0, 0, 1);
      step("wrapr5",    0, 0, 1, 8'h00, 8'h00, 1, 0, 0, 1);

      // Simultaneous read+write on a full FIFO holding 0..3.
      for (int i = 0; i < 4; i++)
         step($sformatf("sfill%0d", i), 0, 1, 0, 8'(i), 8'h00, 0, (i == 3), 0, 0);
      step("rw_full",   0, 1, 1, 8'h09, 8'h01, 0, 1, 0, 0);
      step("chk1",      0, 0, 1, 8'h00, 8'h02, 0, 0, 0, 0);
      step("chk2",      0, 0, 1, 8'h00, 8'h03, 0, 0, 0, 0);
      step("chk3",      0, 0, 1, 8'h00, 8'h09, 0, 0, 0, 0);
      step("chk4",      0, 0, 1, 8'h00, 8'h00, 1, 0, 0, 0);

      // Simultaneous read+write on an empty FIFO: only the write lands.
      step("rw_empty",  0, 1, 1, 8'h05, 8'h05, 0, 0, 0, 1);
      step("mid_w6",    0, 1, 0, 8'h06, 8'h05, 0, 0, 0, 0);
      step("mid_w7",    0, 1, 0, 8'h07, 8'h05, 0, 0, 0, 0);

      // Reset with three entries stored and a write pending.
      step("mid_rst",   1, 1, 0, 8'h08, 8'h00, 1, 0, 0, 0);
      step("post_rst",  0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0);

      // Show-ahead after reset, and read+write on a partly filled FIFO.
      step("sa_w42",    0, 1, 0, 8'h42, 8'h42, 0, 0, 0, 0);
      step("rw_mid",    0, 1, 1, 8'h43, 8'h43, 0, 0, 0, 0);
      step("last_rd",   0, 0, 1, 8'h00, 8'h00, 1, 0, 0, 0);

      @(negedge clk);
      reset = 1'b0; write = 1'b0; read = 1'b0;

      budget = 0;
      while (exp_q.size() > 0 && budget < 10) begin
         @(posedge clk);
         budget++;
      end
      #2;
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fifo_simple.md
Name: fifo_simple

Overview:
- Single-clock synchronous FIFO with parameterisable depth and data width.
- Uses first-word-fall-through (show-ahead): the head entry is always visible on read_data.
- Writes to a full FIFO and reads from an empty FIFO are silently dropped.
- Serves as a small generic buffer between producer and consumer logic in the same clock domain.

Parameters:
- FIFO_DEPTH, 4, number of entries; any integer >= 2 (not required to be a power of two).
- FIFO_DATA_WIDTH, 8, width of each entry in bits.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- write  input  1  push request, sampled at the rising edge of clk.
- read  input  1  pop request, sampled at the rising edge of clk.
- write_data  input  FIFO_DATA_WIDTH  data pushed when a write is accepted.
- read_data  output  FIFO_DATA_WIDTH  current head entry (combinational from storage).
- empty  output  1  high when the FIFO holds 0 entries.
- full  output  1  high when the FIFO holds FIFO_DEPTH entries.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. Reset has priority over read and write.
- On reset:
  - write pointer, read pointer and occupancy count = 0.
  - empty=1, full=0, read_data=0.
  - Storage contents need not be cleared.
- State: write pointer, read pointer (each 0..FIFO_DEPTH-1) and occupancy count (0..FIFO_DEPTH).
- Pointer wrap: a pointer at FIFO_DEPTH-1 advances to 0.
- Write accepted when write=1 and (full=0, or read is accepted in the same cycle).
  - On acceptance: mem[wptr] <= write_data and the write pointer advances.
- Read accepted when read=1 and empty=0.
  - On acceptance: the read pointer advances, and the next entry (or 0 if the FIFO becomes empty) appears on read_data after the edge.
- Rejected operations have no effect on pointers, count, flags or storage. No error indication in the base configuration.
- Count update: +1 on accepted write only, -1 on accepted read only, unchanged when both or neither are accepted.
- Flags:
  - empty = (count==0); full = (count==FIFO_DEPTH).
  - Both are decoded from the registered count, so they change only after a clock edge.
- read_data = mem[rptr] when empty=0, otherwise 0.
- Zero-latency show-ahead: a word written at edge N is visible on read_data right after edge N when the FIFO was empty.
- Simultaneous read+write:
  - Empty FIFO: only the write is accepted; empty deasserts after the edge.
  - Full FIFO: both are accepted; the head is popped, the new word is stored in the freed slot, and full stays 1.
  - Otherwise: both are accepted and the count is unchanged.
- Reset mid-operation: on the reset edge the FIFO returns to the empty state regardless of read/write; any stored data is lost.
- Data ordering: strict first-in first-out, including across any number of pointer wraps.

Optional Feature:
- Macro: FIFO_SIMPLE_ERR_FLAGS_EN.
- When defined, two extra 1-bit outputs are added:
  - overflow: registered; pulses high for exactly one cycle after an edge where write=1 was rejected because the FIFO was full.
  - underflow: registered; pulses high for exactly one cycle after an edge where read=1 was rejected because the FIFO was empty.
  - Both clear to 0 on reset.
- When not defined, these ports do not exist and rejected operations are silent. FIFO behaviour is otherwise identical in both builds.

Test Plan:
1. Reset: hold reset for 2 clocks with write=read=0 -> empty=1, full=0, read_data=0.
2. Overfill: write 0..7 one per clock (depth 4) -> full=1 after the 4th write. Writes 4..7 are dropped, with overflow pulsing 4 times when the macro is enabled. read_data=0 throughout.
3. Overdrain: 6 reads -> read_data shows 0,1,2,3 before successive pops; empty=1 after the 4th pop. Reads 5 and 6 are ignored (underflow pulses twice when enabled) and read_data=0.
4. Wrap-around: after scenario 3, write 16..23 -> 16,17,18,19 stored with the pointers wrapping, full=1. Six reads return 16,17,18,19, then empty=1.
5. Simultaneous operations: on a full FIFO holding 0..3, read+write 9 -> full stays 1 and the contents become 1,2,3,9. On an empty FIFO, read+write 5 -> the count becomes 1 and read_data=5.
6. Reset mid-operation: with 3 entries stored, assert reset for 1 cycle together with write=1 -> empty=1, count 0, and the write is ignored.
